// File: rtl/delay_estimator_pkg.sv
// Shared definitions for the delay estimator: FSM state encoding and width helpers.
package delay_estimator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_MEAS,
        ST_CMP,
        ST_DONE
    } est_state_e;

    // Width of the lag index (at least one bit).
    function automatic int lag_width(input int max_delay);
        return (max_delay > 1) ? $clog2(max_delay) : 1;
    endfunction

    // SAD accumulator width: N+1 bit magnitudes summed over WINDOW samples.
    function automatic int acc_width(input int n, input int window);
        return n + 1 + $clog2(window);
    endfunction

    // Sample counter width, shared by the FILL and MEAS phases.
    function automatic int cnt_width(input int max_delay, input int window);
        int w;
        w = $clog2((max_delay > window) ? max_delay : window);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/delay_estimator_sad.sv
// Absolute-difference accumulator: acc += |a - b| when en, zeroed when clr.
module sad_accumulator #(
    parameter int N     = 16,
    parameter int ACC_W = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic [ACC_W-1:0]    acc
);

    localparam int W = N + 1;

    logic signed [N:0] diff;
    logic [N:0]        abs_diff;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;

    // Difference is formed one bit wider so the extreme operands cannot overflow.
    always_comb begin
        diff     = $signed({a[N-1], a}) - $signed({b[N-1], b});
        abs_diff = diff[N] ? W'(-diff) : W'(diff);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(abs_diff);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/delay_estimator.sv
// Delay estimator: finds the lag (0..MAX_DELAY-1) minimising the SAD between
// dly_in and a delayed copy of ref_in. Assumes MAX_DELAY >= 2.
module delay_estimator
    import delay_estimator_pkg::*;
#(
    parameter int N         = 16,
    parameter int MAX_DELAY = 32,
    parameter int WINDOW    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                clear,
    input  logic                                valid_in,
    input  logic signed [N-1:0]                 ref_in,
    input  logic signed [N-1:0]                 dly_in,
    output logic                                busy,
    output logic                                lag_valid,
    output logic [lag_width(MAX_DELAY)-1:0]     lag,
    output logic [acc_width(N, WINDOW)-1:0]     best_sad
);

    localparam int LAG_W = lag_width(MAX_DELAY);
    localparam int ACC_W = acc_width(N, WINDOW);
    localparam int CNT_W = cnt_width(MAX_DELAY, WINDOW);

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(MAX_DELAY - 2);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [LAG_W-1:0] K_LAST    = LAG_W'(MAX_DELAY - 1);

    est_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAG_W-1:0] k_q, k_d;
    logic [ACC_W-1:0] best_q, best_d;
    logic [LAG_W-1:0] best_lag_q, best_lag_d;
    logic [LAG_W-1:0] lag_q, lag_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic             lag_valid_q, lag_valid_d;

    logic [MAX_DELAY-2:0][N-1:0] hist_q, hist_d;
    logic [MAX_DELAY-1:0][N-1:0] taps;
    logic signed [N-1:0]         tap_k;

    logic [ACC_W-1:0] acc;
    logic             acc_en;
    logic             acc_clr;
    logic             acc_lt;

    // History shifts on every valid sample regardless of FSM state.
    always_comb begin
        hist_d = hist_q;
        if (valid_in) begin
            hist_d[0] = ref_in;
            for (int i = 1; i < MAX_DELAY - 1; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // Tap 0 is the live reference sample, tap j is j valid samples back.
    always_comb begin
        taps[0] = ref_in;
        for (int j = 1; j < MAX_DELAY; j++) begin
            taps[j] = hist_q[j-1];
        end
    end

    assign tap_k  = taps[k_q];
    assign acc_lt = (acc < best_q);

    sad_accumulator #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_sad (
        .clk (clk),
        .rst (rst),
        .en  (acc_en),
        .clr (acc_clr),
        .a   (dly_in),
        .b   (tap_k),
        .acc (acc)
    );

    // FSM next-state, counters, best tracking and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        best_d     = best_q;
        best_lag_d = best_lag_q;
        lag_d      = lag_q;
        best_sad_d = best_sad_q;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    if (start) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (valid_in) begin
                        if (cnt_q == FILL_LAST) begin
                            cnt_d   = '0;
                            k_d     = '0;
                            best_d  = '1;
                            state_d = ST_MEAS;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_MEAS: begin
                    if (valid_in) begin
                        acc_en = 1'b1;
                        if (cnt_q == WIN_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_CMP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CMP: begin
                    acc_clr = 1'b1;
                    k_d     = k_q + LAG_W'(1);
                    if (acc_lt) begin
                        best_d     = acc;
                        best_lag_d = k_q;
                    end
                    if (k_q == K_LAST) begin
                        state_d    = ST_DONE;
                        lag_d      = acc_lt ? k_q : best_lag_q;
                        best_sad_d = acc_lt ? acc : best_q;
                    end else begin
                        state_d = ST_MEAS;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        lag_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            best_q      <= '0;
            best_lag_q  <= '0;
            lag_q       <= '0;
            best_sad_q  <= '0;
            lag_valid_q <= 1'b0;
            hist_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            best_q      <= best_d;
            best_lag_q  <= best_lag_d;
            lag_q       <= lag_d;
            best_sad_q  <= best_sad_d;
            lag_valid_q <= lag_valid_d;
            hist_q      <= hist_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign lag_valid = lag_valid_q;
    assign lag       = lag_q;
    assign best_sad  = best_sad_q;

endmodule

// File: doc/delay_estimator.md
DELAY_ESTIMATOR -- requirements
Module: delay_estimator

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the sample width (signed two's complement).
REQ-002 The module SHALL have parameter MAX_DELAY, default 32, giving the number of candidate lags (0..MAX_DELAY-1).
REQ-003 The module SHALL have parameter WINDOW, default 16 (power of two, ≥2), giving the valid samples accumulated per lag.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin an estimation.
REQ-007 clear  input  1  synchronous abort to IDLE.
REQ-008 valid_in  input  1  ref_in/dly_in carry a sample this cycle.
REQ-009 ref_in  input  N  signed reference stream.
REQ-010 dly_in  input  N  signed delayed copy of the reference stream.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 lag_valid  output  1  one-cycle pulse when lag/best_sad update.
REQ-013 lag  output  clog2(MAX_DELAY)  estimated delay in valid samples.
REQ-014 best_sad  output  N+1+clog2(WINDOW)  SAD of the winning lag.

Function
REQ-015 History SHALL be a MAX_DELAY-1 deep register shift of ref_in that advances only on valid_in, in every state; tap 0 = current ref_in, tap j = ref_in from j valid samples earlier.
REQ-016 Lag k SHALL mean dly_in(sample s) aligns with ref_in(sample s-k).
REQ-017 FSM states SHALL be IDLE, FILL, MEAS, CMP, DONE.
REQ-018 IDLE→FILL on start; start while busy SHALL be ignored.
REQ-019 FILL SHALL count MAX_DELAY-1 valid samples, then go to MEAS with k=0 and best_sad register = all ones.
REQ-020 MEAS SHALL add |dly_in − tap k| (computed at N+1 bits, no overflow) to the accumulator on each valid sample; after WINDOW samples go to CMP.
REQ-021 CMP (one cycle) SHALL replace best when acc < best (strict, so ties keep the smaller lag), clear acc, increment k; go to DONE when k was MAX_DELAY-1, else MEAS.
REQ-022 Samples arriving during CMP SHALL shift history but not be accumulated.
REQ-023 valid_in low SHALL pause FILL/MEAS counting without losing state.
REQ-024 DONE (one cycle) SHALL drive lag_valid=1, register lag and best_sad, and return to IDLE.
REQ-025 lag and best_sad SHALL hold their last value until the next DONE.
REQ-026 The accumulator width SHALL be N+1+clog2(WINDOW); saturation is unnecessary.
REQ-027 clear SHALL return to IDLE in the next cycle from any state, leaving lag/best_sad unchanged and issuing no lag_valid; clear has priority over start.
REQ-028 With continuous valid_in, start-to-lag_valid latency SHALL be 1 + (MAX_DELAY-1) + MAX_DELAY·(WINDOW+1) cycles.

Reset
REQ-029 On rst: state IDLE, history, counters, k and accumulator zero; busy=0, lag_valid=0, lag=0, best_sad=0.
REQ-030 Reset asserted mid-estimation SHALL abort it with no lag_valid pulse after release.

Structure
REQ-031 The state encoding and width helpers (lag width, accumulator width) SHALL live in the shared DSP package.
REQ-032 The |a−b| plus accumulate-and-clear datapath SHALL be one sub-module, sad_accumulator; the FSM, history and compare logic stay in delay_estimator.

Verification
REQ-033 Random ref_in with dly_in = ref_in delayed 5 samples, continuous valid -> one lag_valid, lag=5, best_sad=0, latency per REQ-028.
REQ-034 dly_in = ref_in (lag 0) -> lag=0, best_sad=0; dly_in delayed 31 -> lag=31.
REQ-035 Constant ref_in=dly_in=100 (all lags tie) -> lag=0.
REQ-036 Delay 7 with valid_in toggling 1/0 -> lag=7; an extra start pulse in MEAS is ignored.
REQ-037 ref_in=+32767, dly_in=−32768 constant -> best_sad=65535·16=1048560, no overflow.
REQ-038 clear in MEAS, and rst in FILL -> IDLE, busy=0, no lag_valid, prior lag retained (clear) / zeroed (rst).
